// File: rtl/toggle_pulse_gen.sv
// Purpose : pushbutton front-end; synchronises, debounces both edges, emits one-cycle t pulses (optional auto-repeat).
// Latency : t and btn_db rise at edge 3+DEB_CYCLES after btn rises; btn_db falls 3+DEB_CYCLES edges after release.
// Backpressure: none; en=0 only masks t and evt_cnt, the debounce FSM keeps running.
module toggle_pulse_gen #(
    parameter int DEB_CYCLES    = 4,
    parameter int REPEAT_CYCLES = 0,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       en,
    output logic       t,
    output logic       btn_db,
    output logic [7:0] evt_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DB_HI = 2'd1,
        HELD  = 2'd2,
        DB_LO = 2'd3
    } state_t;

    // Terminal counts; REP_LAST is meaningless when repeat is disabled and is
    // always qualified by REP_EN.
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic             REP_EN   = (REPEAT_CYCLES != 0);

    logic             s1;
    logic             s2;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] rcnt;
    logic [CNT_W-1:0] rcnt_nxt;
    logic             btn_db_nxt;
    logic             pulse;
    logic             t_nxt;
    logic [7:0]       evt_cnt_nxt;

    // Two-flop synchroniser for the asynchronous button; only s2 is used downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // State, counters and registered outputs; reset drops any pending pulse at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rcnt    <= '0;
            btn_db  <= 1'b0;
            t       <= 1'b0;
            evt_cnt <= 8'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rcnt    <= rcnt_nxt;
            btn_db  <= btn_db_nxt;
            t       <= t_nxt;
            evt_cnt <= evt_cnt_nxt;
        end
    end

    // Next-state logic: debounce both edges, decide when a pulse is issued.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        rcnt_nxt   = rcnt;
        btn_db_nxt = btn_db;
        pulse      = 1'b0;

        unique case (state)
            IDLE: begin
                if (s2) begin
                    state_nxt = DB_HI;
                    cnt_nxt   = '0;
                end
            end

            DB_HI: begin
                if (!s2) begin
                    // Press glitch shorter than the debounce window.
                    state_nxt = IDLE;
                end else if (cnt == DEB_LAST) begin
                    state_nxt  = HELD;
                    btn_db_nxt = 1'b1;
                    rcnt_nxt   = '0;
                    pulse      = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            HELD: begin
                if (!s2) begin
                    state_nxt = DB_LO;
                    cnt_nxt   = '0;
                end else if (REP_EN && (rcnt == REP_LAST)) begin
                    pulse    = 1'b1;
                    rcnt_nxt = '0;
                end else if (REP_EN) begin
                    rcnt_nxt = rcnt + 1'b1;
                end else begin
                    rcnt_nxt = '0;
                end
            end

            DB_LO: begin
                if (s2) begin
                    // Release bounce: back to held, repeat interval restarts.
                    state_nxt = HELD;
                    rcnt_nxt  = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt  = IDLE;
                    btn_db_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Pulse gating: en is looked at only in the decision cycle.
    always_comb begin
        t_nxt       = pulse & en;
        evt_cnt_nxt = evt_cnt;
        if (pulse && en) begin
            evt_cnt_nxt = evt_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Bench for toggle_pulse_gen: one instance without repeat, one with REPEAT_CYCLES=8.
// Directed scenarios use edge-numbered expectations; random phase uses a window-based model.
module tb_toggle_pulse_gen;

    localparam int DEB = 4;

    logic       clk;
    logic       rst;
    logic       btn;
    logic       en;
    logic       t0, db0, t1, db1;
    logic [7:0] cnt0, cnt1;

    int vecs = 0;
    int errs = 0;
    int e    = 0;

    toggle_pulse_gen #(.DEB_CYCLES(4), .REPEAT_CYCLES(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .btn(btn), .en(en),
        .t(t0), .btn_db(db0), .evt_cnt(cnt0)
    );

    toggle_pulse_gen #(.DEB_CYCLES(4), .REPEAT_CYCLES(8), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .btn(btn), .en(en),
        .t(t1), .btn_db(db1), .evt_cnt(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // btn is seen by the decision logic two edges late. The debounced level
    // flips once the last DEB+1 decision samples all disagree with it. Repeat
    // pulses fire every R edges measured from the last pulse, the press, or a
    // return from a release bounce.
    bit        samp_q[$];
    bit        s2_q[$];
    bit        m_db;
    bit        m_t   [2];
    int        m_cnt [2];
    int        m_anc [2];
    int        m_edge;
    int        rep_of[2] = '{0, 8};
    bit        m_s2, m_prev, m_rise, m_fall, m_ones, m_zeros, m_pulse;
    int        m_n;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp_q.delete();
            s2_q.delete();
            m_db   = 1'b0;
            m_edge = 0;
            for (int i = 0; i < 2; i++) begin
                m_t[i] = 1'b0; m_cnt[i] = 0; m_anc[i] = 0;
            end
        end else begin
            m_edge = m_edge + 1;
            m_s2   = (samp_q.size() >= 2) ? samp_q[samp_q.size()-2] : 1'b0;
            samp_q.push_back(btn);
            s2_q.push_back(m_s2);
            m_n    = s2_q.size();
            m_prev = (m_n >= 2) ? s2_q[m_n-2] : 1'b0;
            m_ones = 1'b0; m_zeros = 1'b0;
            if (m_n >= DEB + 1) begin
                m_ones = 1'b1; m_zeros = 1'b1;
                for (int j = m_n - (DEB + 1); j < m_n; j++) begin
                    if (s2_q[j]) m_zeros = 1'b0;
                    else         m_ones  = 1'b0;
                end
            end
            m_rise = !m_db && m_ones;
            m_fall = m_db && m_zeros;
            for (int i = 0; i < 2; i++) begin
                m_t[i]  = 1'b0;
                m_pulse = 1'b0;
                if (m_rise) begin
                    m_pulse  = 1'b1;
                    m_anc[i] = m_edge;
                end else if (m_db && m_s2) begin
                    if (!m_prev) m_anc[i] = m_edge;
                    else if (rep_of[i] != 0 && (m_edge - m_anc[i]) == rep_of[i]) begin
                        m_pulse  = 1'b1;
                        m_anc[i] = m_edge;
                    end
                end
                if (m_pulse && en) begin
                    m_t[i]   = 1'b1;
                    m_cnt[i] = (m_cnt[i] + 1) % 256;
                end
            end
            if (m_rise) m_db = 1'b1;
            if (m_fall) m_db = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset(input logic b, input logic en_v);
        @(negedge clk);
        rst = 1'b0; btn = 1'b0; en = en_v;
        repeat (2) @(negedge clk);
        btn = b; rst = 1'b1; e = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        e = e + 1;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; btn = 1'b1; en = 1'b1;
        #1;
        vecs += 6;
        if (t0 !== 1'b0)    begin errs++; $display("FAIL reset_t0: got %b want 0", t0); end
        if (db0 !== 1'b0)   begin errs++; $display("FAIL reset_db0: got %b want 0", db0); end
        if (cnt0 !== 8'd0)  begin errs++; $display("FAIL reset_cnt0: got %0d want 0", cnt0); end
        if (t1 !== 1'b0)    begin errs++; $display("FAIL reset_t1: got %b want 0", t1); end
        if (db1 !== 1'b0)   begin errs++; $display("FAIL reset_db1: got %b want 0", db1); end
        if (cnt1 !== 8'd0)  begin errs++; $display("FAIL reset_cnt1: got %0d want 0", cnt1); end
        repeat (3) @(negedge clk);
        vecs += 2;
        if (db0 !== 1'b0)   begin errs++; $display("FAIL reset_hold_db0: got %b want 0", db0); end
        if (t0 !== 1'b0)    begin errs++; $display("FAIL reset_hold_t0: got %b want 0", t0); end
        btn = 1'b0; rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single_press();
        logic ex_t0, ex_db, ex_t1;
        do_reset(1'b1, 1'b1);
        for (int k = 1; k <= 30; k++) begin
            tick();
            ex_t0 = (k == 7);
            ex_t1 = (k == 7) || (k == 15);
            ex_db = (k >= 7) && (k < 27);
            vecs += 4;
            if (t0 !== ex_t0)  begin errs++; $display("FAIL press_t0 edge %0d: got %b want %b", k, t0, ex_t0); end
            if (db0 !== ex_db) begin errs++; $display("FAIL press_db0 edge %0d: got %b want %b", k, db0, ex_db); end
            if (t1 !== ex_t1)  begin errs++; $display("FAIL press_t1 edge %0d: got %b want %b", k, t1, ex_t1); end
            if (db1 !== ex_db) begin errs++; $display("FAIL press_db1 edge %0d: got %b want %b", k, db1, ex_db); end
            if (k == 20) btn = 1'b0;
        end
        vecs += 2;
        if (cnt0 !== 8'd1) begin errs++; $display("FAIL press_cnt0: got %0d want 1", cnt0); end
        if (cnt1 !== 8'd2) begin errs++; $display("FAIL press_cnt1: got %0d want 2", cnt1); end
    endtask

    task automatic test_short_press();
        do_reset(1'b1, 1'b1);
        for (int k = 1; k <= 15; k++) begin
            tick();
            vecs += 3;
            if (t0 !== 1'b0)  begin errs++; $display("FAIL glitch_t0 edge %0d: got %b want 0", k, t0); end
            if (db0 !== 1'b0) begin errs++; $display("FAIL glitch_db0 edge %0d: got %b want 0", k, db0); end
            if (t1 !== 1'b0)  begin errs++; $display("FAIL glitch_t1 edge %0d: got %b want 0", k, t1); end
            if (k == 2) btn = 1'b0;
        end
        vecs += 1;
        if (cnt0 !== 8'd0) begin errs++; $display("FAIL glitch_cnt0: got %0d want 0", cnt0); end
    endtask

    task automatic test_repeat();
        logic ex_t1, ex_db;
        do_reset(1'b1, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            tick();
            ex_t1 = (k == 7) || (k == 15) || (k == 23) || (k == 31);
            ex_db = (k >= 7) && (k < 37);
            vecs += 2;
            if (t1 !== ex_t1)  begin errs++; $display("FAIL repeat_t1 edge %0d: got %b want %b", k, t1, ex_t1); end
            if (db1 !== ex_db) begin errs++; $display("FAIL repeat_db1 edge %0d: got %b want %b", k, db1, ex_db); end
            if (k == 30) btn = 1'b0;
        end
        vecs += 2;
        if (cnt1 !== 8'd4) begin errs++; $display("FAIL repeat_cnt1: got %0d want 4", cnt1); end
        if (cnt0 !== 8'd1) begin errs++; $display("FAIL repeat_cnt0: got %0d want 1", cnt0); end
    endtask

    task automatic test_en_off();
        logic ex_db;
        do_reset(1'b1, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            ex_db = (k >= 7);
            vecs += 3;
            if (t0 !== 1'b0)   begin errs++; $display("FAIL en_off_t0 edge %0d: got %b want 0", k, t0); end
            if (t1 !== 1'b0)   begin errs++; $display("FAIL en_off_t1 edge %0d: got %b want 0", k, t1); end
            if (db0 !== ex_db) begin errs++; $display("FAIL en_off_db0 edge %0d: got %b want %b", k, db0, ex_db); end
        end
        vecs += 2;
        if (cnt0 !== 8'd0) begin errs++; $display("FAIL en_off_cnt0: got %0d want 0", cnt0); end
        if (cnt1 !== 8'd0) begin errs++; $display("FAIL en_off_cnt1: got %0d want 0", cnt1); end
        btn = 1'b0; en = 1'b1;
    endtask

    task automatic test_release_bounce();
        logic ex_t0, ex_t1, ex_db;
        do_reset(1'b1, 1'b1);
        for (int k = 1; k <= 34; k++) begin
            tick();
            ex_t0 = (k == 7);
            ex_t1 = (k == 7) || (k == 25);
            ex_db = (k >= 7);
            vecs += 3;
            if (t0 !== ex_t0)  begin errs++; $display("FAIL bounce_t0 edge %0d: got %b want %b", k, t0, ex_t0); end
            if (t1 !== ex_t1)  begin errs++; $display("FAIL bounce_t1 edge %0d: got %b want %b", k, t1, ex_t1); end
            if (db0 !== ex_db) begin errs++; $display("FAIL bounce_db0 edge %0d: got %b want %b", k, db0, ex_db); end
            if (k == 12) btn = 1'b0;
            if (k == 14) btn = 1'b1;
            if (k == 30) btn = 1'b0;
        end
        vecs += 2;
        if (cnt0 !== 8'd1) begin errs++; $display("FAIL bounce_cnt0: got %0d want 1", cnt0); end
        if (cnt1 !== 8'd2) begin errs++; $display("FAIL bounce_cnt1: got %0d want 2", cnt1); end
    endtask

    task automatic test_reset_mid_held();
        logic ex_t0, ex_db;
        do_reset(1'b1, 1'b1);
        repeat (7) tick();
        vecs += 1;
        if (t0 !== 1'b1) begin errs++; $display("FAIL midrst_pre_t0: got %b want 1", t0); end
        rst = 1'b0;
        #1;
        vecs += 5;
        if (t0 !== 1'b0)   begin errs++; $display("FAIL midrst_t0: got %b want 0", t0); end
        if (t1 !== 1'b0)   begin errs++; $display("FAIL midrst_t1: got %b want 0", t1); end
        if (db0 !== 1'b0)  begin errs++; $display("FAIL midrst_db0: got %b want 0", db0); end
        if (cnt0 !== 8'd0) begin errs++; $display("FAIL midrst_cnt0: got %0d want 0", cnt0); end
        if (cnt1 !== 8'd0) begin errs++; $display("FAIL midrst_cnt1: got %0d want 0", cnt1); end
        repeat (2) @(negedge clk);
        rst = 1'b1; e = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            ex_t0 = (k == 7);
            ex_db = (k >= 7);
            vecs += 2;
            if (t0 !== ex_t0)  begin errs++; $display("FAIL midrst_again_t0 edge %0d: got %b want %b", k, t0, ex_t0); end
            if (db0 !== ex_db) begin errs++; $display("FAIL midrst_again_db0 edge %0d: got %b want %b", k, db0, ex_db); end
        end
        vecs += 1;
        if (cnt0 !== 8'd1) begin errs++; $display("FAIL midrst_cnt0_after: got %0d want 1", cnt0); end
        btn = 1'b0;
    endtask

    task automatic test_counter_wrap();
        logic       ex_t1;
        logic [7:0] ex_cnt;
        do_reset(1'b1, 1'b1);
        for (int k = 1; k <= 2060; k++) begin
            tick();
            ex_t1  = (k >= 7) && (((k - 7) % 8) == 0);
            ex_cnt = (k < 7) ? 8'd0 : 8'((((k - 7) / 8) + 1) % 256);
            vecs += 2;
            if (t1 !== ex_t1)    begin errs++; $display("FAIL wrap_t1 edge %0d: got %b want %b", k, t1, ex_t1); end
            if (cnt1 !== ex_cnt) begin errs++; $display("FAIL wrap_cnt1 edge %0d: got %0d want %0d", k, cnt1, ex_cnt); end
        end
        btn = 1'b0;
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        do_reset(1'b0, 1'b1);
        for (int k = 1; k <= 3000; k++) begin
            if (hold == 0) begin
                btn  = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 12);
            end
            hold = hold - 1;
            en = ($urandom_range(0, 7) != 0);
            tick();
            vecs += 6;
            if (t0 !== m_t[0])          begin errs++; $display("FAIL rand_t0 cyc %0d: got %b want %b", k, t0, m_t[0]); end
            if (db0 !== m_db)           begin errs++; $display("FAIL rand_db0 cyc %0d: got %b want %b", k, db0, m_db); end
            if (cnt0 !== 8'(m_cnt[0]))  begin errs++; $display("FAIL rand_cnt0 cyc %0d: got %0d want %0d", k, cnt0, m_cnt[0]); end
            if (t1 !== m_t[1])          begin errs++; $display("FAIL rand_t1 cyc %0d: got %b want %b", k, t1, m_t[1]); end
            if (db1 !== m_db)           begin errs++; $display("FAIL rand_db1 cyc %0d: got %b want %b", k, db1, m_db); end
            if (cnt1 !== 8'(m_cnt[1]))  begin errs++; $display("FAIL rand_cnt1 cyc %0d: got %0d want %0d", k, cnt1, m_cnt[1]); end
        end
    endtask

    initial begin
        rst = 1'b1; btn = 1'b0; en = 1'b1;
        test_reset();
        test_single_press();
        test_short_press();
        test_repeat();
        test_en_off();
        test_release_bounce();
        test_reset_mid_held();
        test_counter_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
